// File: rtl/parity_pkg.sv
// Shared types for the parity-share arbiter: FSM state encoding and
// request-type constants seen on req_check.
package parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam logic REQ_GEN   = 1'b0;
    localparam logic REQ_CHECK = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request found
// when scanning upward from ptr_i, wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int SRC_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [SRC_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [SRC_W-1:0] idx_o
);

    logic             found;
    logic [SRC_W-1:0] cand;

    // Priority scan starting at the round-robin pointer.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = SRC_W'((int'(ptr_i) + k) % N_REQ);
            if (en_i && !found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/parity_share_arbiter.sv
// Time-shares one bit-serial odd-parity engine between N_REQ requesters.
// A granted word is shifted through the engine LSB first, then the result
// is held on the output side until the consumer accepts it.
module parity_share_arbiter
    import parity_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int SRC_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_check,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_par,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_parity,
    output logic                    out_err,
    output logic [SRC_W-1:0]        out_src,
    output logic [CNT_W-1:0]        err_count,
    input  logic                    err_clr
);

    localparam int               BC_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] s);
        return (int'(s) == N_REQ - 1) ? '0 : s + SRC_W'(1);
    endfunction

    state_e            state_q, state_d;
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              check_q, check_d;
    logic              par_q, par_d;
    logic [SRC_W-1:0]  src_q, src_d;
    logic              acc_q, acc_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic              ov_q, ov_d;
    logic [DATA_W-1:0] od_q, od_d;
    logic              op_q, op_d;
    logic              oe_q, oe_d;
    logic [SRC_W-1:0]  os_q, os_d;
    logic [CNT_W-1:0]  err_q, err_d;

    logic [N_REQ-1:0]  gnt;
    logic [SRC_W-1:0]  gnt_idx;
    logic [DATA_W-1:0] sel_data;
    logic              sel_check;
    logic              sel_par;
    logic              acc_next;
    logic              hs;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .SRC_W (SRC_W)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .en_i    (state_q == ST_IDLE),
        .grant_o (gnt),
        .idx_o   (gnt_idx)
    );

    // Mux the granted requester's word, type and parity bit.
    always_comb begin
        sel_data  = '0;
        sel_check = 1'b0;
        sel_par   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_data  = sel_data | (req_data[i*DATA_W +: DATA_W] & {DATA_W{gnt[i]}});
            sel_check = sel_check | (req_check[i] & gnt[i]);
            sel_par   = sel_par | (req_par[i] & gnt[i]);
        end
    end

    assign acc_next = acc_q ^ data_q[bit_cnt_q];

    // Next-state, capture, serial accumulate and output-register loading.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        data_d    = data_q;
        check_d   = check_q;
        par_d     = par_q;
        src_d     = src_q;
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        ov_d      = ov_q;
        od_d      = od_q;
        op_d      = op_q;
        oe_d      = oe_q;
        os_d      = os_q;
        hs        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    data_d    = sel_data;
                    check_d   = (sel_check == REQ_CHECK);
                    par_d     = sel_par;
                    src_d     = gnt_idx;
                    acc_d     = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d     = acc_next;
                bit_cnt_d = bit_cnt_q + BC_W'(1);
                if (bit_cnt_q == BC_LAST) begin
                    // Load the result registers so HOLD presents them directly.
                    state_d = ST_HOLD;
                    ov_d    = 1'b1;
                    od_d    = data_q;
                    op_d    = ~acc_next;
                    oe_d    = check_q & ~(acc_next ^ par_q);
                    os_d    = src_q;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    hs       = 1'b1;
                    ov_d     = 1'b0;
                    rr_ptr_d = next_ptr(src_q);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear wins over a coincident failing handshake.
        err_d = err_q;
        if (err_clr) begin
            err_d = '0;
        end else if (hs && oe_q) begin
            err_d = sat_inc(err_q);
        end
    end

    // FSM, pointer, output and error-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            ov_q     <= 1'b0;
            od_q     <= '0;
            op_q     <= 1'b0;
            oe_q     <= 1'b0;
            os_q     <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            ov_q     <= ov_d;
            od_q     <= od_d;
            op_q     <= op_d;
            oe_q     <= oe_d;
            os_q     <= os_d;
            err_q    <= err_d;
        end
    end

    // Capture and serial engine registers; always reloaded at grant.
    always_ff @(posedge clk) begin
        data_q    <= data_d;
        check_q   <= check_d;
        par_q     <= par_d;
        src_q     <= src_d;
        acc_q     <= acc_d;
        bit_cnt_q <= bit_cnt_d;
    end

    assign req_ready  = gnt;
    assign out_valid  = ov_q;
    assign out_data   = od_q;
    assign out_parity = op_q;
    assign out_err    = oe_q;
    assign out_src    = os_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_parity_share_arbiter.sv
// Directed bench for parity_share_arbiter (N_REQ=4, DATA_W=8, CNT_W=8).
module tb_parity_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_check;
    logic [31:0] req_data;
    logic [3:0]  req_par;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_parity;
    logic        out_err;
    logic [1:0]  out_src;
    logic [7:0]  err_count;
    logic        err_clr;

    int n_checks = 0;
    int n_pass   = 0;

    parity_share_arbiter #(
        .N_REQ (4), .DATA_W (8), .SRC_W (2), .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_check  (req_check),
        .req_data   (req_data),
        .req_par    (req_par),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_parity (out_parity),
        .out_err    (out_err),
        .out_src    (out_src),
        .err_count  (err_count),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Raise request i from IDLE, capture req_ready in the grant cycle, drop the
    // request after the grant and count cycles until out_valid (bounded).
    task automatic do_txn(input int i, input logic chk, input logic [7:0] d,
                          input logic p, output logic [3:0] rdy, output int lat);
        req_valid[i] = 1'b1;
        req_check[i] = chk;
        req_data[i*8 +: 8] = d;
        req_par[i] = p;
        #1;
        rdy = req_ready;
        tick();
        req_valid[i] = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b exp 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 8'h00) $display("FAIL reset_data: got %h exp 00", out_data); else n_pass++;
        n_checks++; if ({out_parity, out_err, out_src} !== 4'b0) $display("FAIL reset_flags: got %b exp 0000", {out_parity, out_err, out_src}); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL reset_errcnt: got %0d exp 0", err_count); else n_pass++;
        n_checks++; if (req_ready !== 4'b0) $display("FAIL reset_ready: got %b exp 0000", req_ready); else n_pass++;
    endtask

    task automatic test_gen_single();
        logic [3:0] rdy;
        int lat;
        do_txn(0, 1'b0, 8'hA5, 1'b0, rdy, lat);
        n_checks++; if (rdy !== 4'b0001) $display("FAIL gen1_ready: got %b exp 0001", rdy); else n_pass++;
        n_checks++; if (lat !== 9) $display("FAIL gen1_latency: got %0d exp 9", lat); else n_pass++;
        n_checks++; if (out_parity !== 1'b1) $display("FAIL gen1_parity: got %0b exp 1", out_parity); else n_pass++;
        n_checks++; if (out_err !== 1'b0) $display("FAIL gen1_err: got %0b exp 0", out_err); else n_pass++;
        n_checks++; if (out_src !== 2'd0) $display("FAIL gen1_src: got %0d exp 0", out_src); else n_pass++;
        n_checks++; if (out_data !== 8'hA5) $display("FAIL gen1_data: got %h exp a5", out_data); else n_pass++;
        handshake();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL gen1_valid_drop: got %0b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_gen_odd();
        logic [3:0] rdy;
        int lat;
        do_txn(2, 1'b0, 8'h07, 1'b0, rdy, lat);
        n_checks++; if (rdy !== 4'b0100) $display("FAIL gen2_ready: got %b exp 0100", rdy); else n_pass++;
        n_checks++; if (out_parity !== 1'b0) $display("FAIL gen2_parity: got %0b exp 0", out_parity); else n_pass++;
        n_checks++; if (out_src !== 2'd2) $display("FAIL gen2_src: got %0d exp 2", out_src); else n_pass++;
        handshake();
    endtask

    task automatic test_check();
        logic [3:0] rdy;
        int lat;
        do_txn(1, 1'b1, 8'h03, 1'b1, rdy, lat);
        n_checks++; if (rdy !== 4'b0010) $display("FAIL chk_ok_ready: got %b exp 0010", rdy); else n_pass++;
        n_checks++; if (out_err !== 1'b0) $display("FAIL chk_ok_err: got %0b exp 0", out_err); else n_pass++;
        n_checks++; if (out_parity !== 1'b1) $display("FAIL chk_ok_parity: got %0b exp 1", out_parity); else n_pass++;
        handshake();
        n_checks++; if (err_count !== 8'd0) $display("FAIL chk_ok_cnt: got %0d exp 0", err_count); else n_pass++;
        do_txn(1, 1'b1, 8'h03, 1'b0, rdy, lat);
        n_checks++; if (out_err !== 1'b1) $display("FAIL chk_bad_err: got %0b exp 1", out_err); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL chk_bad_cnt_pre: got %0d exp 0", err_count); else n_pass++;
        handshake();
        n_checks++; if (err_count !== 8'd1) $display("FAIL chk_bad_cnt: got %0d exp 1", err_count); else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int got_idx[5];
        int got_cyc[5];
        int ng = 0;
        do_reset();
        req_valid = 4'b1111;
        req_check = 4'b0000;
        req_data  = 32'h44332211;
        out_ready = 1'b1;
        for (int c = 0; c < 100 && ng < 5; c++) begin
            #1;
            if (req_ready !== 4'b0000) begin
                got_idx[ng] = -1;
                for (int b = 0; b < 4; b++) if (req_ready == (4'b0001 << b)) got_idx[ng] = b;
                got_cyc[ng] = c;
                ng++;
            end
            tick();
        end
        req_valid = 4'b0000;
        n_checks++; if (ng !== 5) $display("FAIL rr_count: got %0d exp 5", ng); else n_pass++;
        for (int k = 0; k < ng; k++) begin
            n_checks++; if (got_idx[k] !== exp_order[k]) $display("FAIL rr_order%0d: got %0d exp %0d", k, got_idx[k], exp_order[k]); else n_pass++;
        end
        for (int k = 1; k < ng; k++) begin
            n_checks++; if (got_cyc[k] - got_cyc[k-1] !== 10) $display("FAIL rr_period%0d: got %0d exp 10", k, got_cyc[k] - got_cyc[k-1]); else n_pass++;
        end
        repeat (12) tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rr_drain: got %0b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_hold_stall();
        logic [3:0] rdy;
        int lat;
        int w;
        req_valid[2] = 1'b1;
        req_check[2] = 1'b0;
        req_data[23:16] = 8'h0F;
        do_txn(1, 1'b0, 8'hF0, 1'b0, rdy, lat);
        n_checks++; if (rdy !== 4'b0010) $display("FAIL stall_grant: got %b exp 0010", rdy); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({out_valid, out_data, out_parity, out_err, out_src, req_ready} !== {1'b1, 8'hF0, 1'b1, 1'b0, 2'd1, 4'b0000})
                $display("FAIL stall_cycle%0d: got v=%0b d=%h p=%0b e=%0b s=%0d rdy=%b exp v=1 d=f0 p=1 e=0 s=1 rdy=0000",
                         c, out_valid, out_data, out_parity, out_err, out_src, req_ready);
            else n_pass++;
            tick();
        end
        handshake();
        n_checks++; if (req_ready !== 4'b0100) $display("FAIL stall_next_grant: got %b exp 0100", req_ready); else n_pass++;
        tick();
        req_valid[2] = 1'b0;
        w = 0;
        while (!out_valid && w < 60) begin tick(); w++; end
        n_checks++; if ({out_src, out_parity} !== {2'd2, 1'b1}) $display("FAIL stall_next_out: got s=%0d p=%0b exp s=2 p=1", out_src, out_parity); else n_pass++;
        handshake();
    endtask

    task automatic test_saturation();
        logic [3:0] rdy;
        int lat;
        do_reset();
        for (int n = 0; n < 255; n++) begin
            do_txn(0, 1'b1, 8'h00, 1'b0, rdy, lat);
            handshake();
        end
        n_checks++; if (err_count !== 8'd255) $display("FAIL sat_255: got %0d exp 255", err_count); else n_pass++;
        do_txn(0, 1'b1, 8'h00, 1'b0, rdy, lat);
        n_checks++; if (out_err !== 1'b1) $display("FAIL sat_err: got %0b exp 1", out_err); else n_pass++;
        handshake();
        n_checks++; if (err_count !== 8'd255) $display("FAIL sat_hold: got %0d exp 255", err_count); else n_pass++;
    endtask

    task automatic test_clear_coincident();
        logic [3:0] rdy;
        int lat;
        do_txn(0, 1'b1, 8'h00, 1'b0, rdy, lat);
        err_clr = 1'b1;
        handshake();
        err_clr = 1'b0;
        n_checks++; if (err_count !== 8'd0) $display("FAIL clr_coinc: got %0d exp 0", err_count); else n_pass++;
        do_txn(0, 1'b1, 8'h00, 1'b0, rdy, lat);
        handshake();
        n_checks++; if (err_count !== 8'd1) $display("FAIL clr_after: got %0d exp 1", err_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [3:0] rdy;
        int lat;
        int w;
        // Abort during the fourth SHIFT cycle.
        req_valid[1] = 1'b1;
        req_check[1] = 1'b0;
        req_data[15:8] = 8'h5A;
        tick();
        req_valid[1] = 1'b0;
        repeat (3) tick();
        req_valid[3] = 1'b1;
        req_check[3] = 1'b0;
        req_data[31:24] = 8'h01;
        do_reset();
        n_checks++; if ({out_valid, out_data, out_parity, out_err, out_src, err_count} !== 20'b0)
            $display("FAIL rst_shift_outs: got v=%0b d=%h p=%0b e=%0b s=%0d c=%0d exp all 0", out_valid, out_data, out_parity, out_err, out_src, err_count);
            else n_pass++;
        n_checks++; if (req_ready !== 4'b1000) $display("FAIL rst_shift_grant: got %b exp 1000", req_ready); else n_pass++;
        tick();
        req_valid[3] = 1'b0;
        w = 0;
        while (!out_valid && w < 60) begin tick(); w++; end
        n_checks++; if ({out_src, out_parity, out_data} !== {2'd3, 1'b0, 8'h01}) $display("FAIL rst_shift_out: got s=%0d p=%0b d=%h exp s=3 p=0 d=01", out_src, out_parity, out_data); else n_pass++;
        handshake();
        // Move the pointer to 2, then abort in HOLD; the pointer must return to 0.
        do_txn(1, 1'b1, 8'h00, 1'b0, rdy, lat);
        handshake();
        do_txn(2, 1'b1, 8'h00, 1'b0, rdy, lat);
        n_checks++; if (rdy !== 4'b0100) $display("FAIL rst_hold_grant_pre: got %b exp 0100", rdy); else n_pass++;
        do_reset();
        n_checks++; if ({out_valid, err_count} !== 9'b0) $display("FAIL rst_hold_outs: got v=%0b c=%0d exp v=0 c=0", out_valid, err_count); else n_pass++;
        req_valid = 4'b1010;
        #1;
        n_checks++; if (req_ready !== 4'b0010) $display("FAIL rst_hold_ptr: got %b exp 0010", req_ready); else n_pass++;
        tick();
        req_valid = 4'b0000;
        w = 0;
        while (!out_valid && w < 60) begin tick(); w++; end
        handshake();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_check = '0;
        req_data  = '0;
        req_par   = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        tick();
        test_reset();
        test_gen_single();
        test_gen_odd();
        test_check();
        test_round_robin();
        test_hold_stall();
        test_saturation();
        test_clear_coincident();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
